uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
- REQ-001 SHALL have parameter NREQ, default 4: number of requesters, fixed at 4 (2-bit grant index).
- REQ-002 SHALL have parameter TIMEOUT, default 16'd50000: watchdog limit in clk cycles; used only with UART_ARB_TIMEOUT_EN.
- REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
- REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
- REQ-005 SHALL have port req  input  4  per-requester send request, level, held until ack.
- REQ-006 SHALL have port din  input  32  requester byte i on din[8i+7:8i], stable while req[i]=1.
- REQ-007 SHALL have port ack  output  4  one-cycle pulse: byte of requester i consumed.
- REQ-008 SHALL have port tx_din  output  8  byte to transmitter, registered.
- REQ-009 SHALL have port tx_en  output  1  one-cycle load strobe to transmitter.
- REQ-010 SHALL have port tx_rdy  input  1  transmitter idle (1) / busy (0).
- REQ-011 SHALL have port busy  output  1  arbiter not in IDLE.
- REQ-012 SHALL have port gnt_id  output  2  index of current/last granted requester.
- REQ-013 SHALL have port err  output  1  one-cycle pulse on watchdog abort.

Function
- REQ-014 SHALL implement FSM states IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- REQ-015 IDLE: if tx_rdy=1 and req!=0, SHALL select winner round-robin starting at ptr (ptr, ptr+1, ... mod 4), register gnt_id and tx_din=din[winner], go LOAD; else stay.
- REQ-016 LOAD (exactly 1 cycle): SHALL assert tx_en=1 and ack[gnt_id]=1, then go WAIT_BUSY; latency req-sampled-in-IDLE to tx_en = 1 cycle.
- REQ-017 WAIT_BUSY: SHALL go WAIT_DONE on first cycle tx_rdy=0.
- REQ-018 WAIT_DONE: SHALL go IDLE on first cycle tx_rdy=1 and set ptr=gnt_id+1 (2-bit wrap, 3->0).
- REQ-019 tx_din SHALL hold its value outside IDLE-to-LOAD transitions; tx_en and ack SHALL be 0 in every state except LOAD.
- REQ-020 Requester dropping req after selection SHALL NOT cancel the transfer; byte already captured is sent and ack still pulses.
- REQ-021 Simultaneous requests SHALL be served one per transfer; with all 4 held continuously, grants SHALL cycle 0,1,2,3,0...
- REQ-022 tx_rdy=0 while in IDLE SHALL block selection; no tx_en issued.
- REQ-023 busy SHALL equal (state!=IDLE), combinational from state register.
- REQ-024 ack SHALL never have more than one bit set.

Reset
- REQ-025 rst=0 SHALL asynchronously force state=IDLE, ptr=0, gnt_id=0, tx_din=8'h00, tx_en=0, ack=0, err=0, busy=0, watchdog count=0.
- REQ-026 Reset mid-transfer SHALL abandon the transfer without ack; after release, arbitration restarts from ptr=0.

Configuration
- REQ-027 Macro UART_ARB_TIMEOUT_EN defined: 16-bit counter SHALL clear on LOAD, increment each cycle in WAIT_BUSY/WAIT_DONE; on reaching TIMEOUT, SHALL pulse err 1 cycle, set ptr=gnt_id+1, return to IDLE.
- REQ-028 Macro undefined: no counter SHALL be synthesized, err tied 0, WAIT_BUSY/WAIT_DONE wait indefinitely.

Verification
- REQ-029 Single: req=4'b0100, din[23:16]=8'hA5, tx_rdy toggles 1->0 (3 cycles)->1 -> one tx_en with tx_din=8'hA5, ack=4'b0100 same cycle, gnt_id=2, busy back to 0.
- REQ-030 Contention: req=4'b1111 held, transmitter model busy 10 cycles per byte -> ack order 0001,0010,0100,1000,0001.
- REQ-031 Fairness wrap: ptr=3 after grant 2, req=4'b1001 -> grant 3 then 0.
- REQ-032 Blocked: tx_rdy=0 in IDLE with req=4'b0001 for 20 cycles -> tx_en stays 0, busy 0; tx_rdy=1 -> tx_en 1 cycle later.
- REQ-033 Reset mid-op: rst=0 during WAIT_DONE -> all outputs to reset values same cycle, no ack; next grant from ptr=0.
- REQ-034 Timeout (macro on, TIMEOUT=100): tx_rdy stuck 0 after LOAD -> err pulse 100 cycles after LOAD, busy=0 next cycle; macro off -> err never asserts.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding bytes from NREQ requesters into a single UART transmitter.
// Optional watchdog on the transmitter handshake: define UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
  parameter int          NREQ    = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] din,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        tx_din,
  output logic              tx_en,
  input  logic              tx_rdy,
  output logic              busy,
  output logic [1:0]        gnt_id,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [7:0]  txd_q, txd_d;
  logic        win_vld;
  logic [1:0]  win_idx;
  logic        wd_hit;

  // Scan from ptr upwards; descending loop so the nearest requester wins.
  always_comb begin
    logic [1:0] idx;
    win_vld = 1'b0;
    win_idx = 2'd0;
    idx     = 2'd0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        in_wait;

  assign in_wait = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
  // Counter holds cycles spent waiting minus one, so the hit lands TIMEOUT cycles after LOAD.
  assign wd_hit  = in_wait && (wd_cnt_q == TIMEOUT - 16'd1);

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == S_LOAD) wd_cnt_d = 16'd0;
    else if (in_wait)      wd_cnt_d = wd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wd_cnt_q <= 16'd0;
    else      wd_cnt_q <= wd_cnt_d;
  end

  assign err = wd_hit;
`else
  assign wd_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    txd_d   = txd_q;
    unique case (state_q)
      S_IDLE: begin
        if (tx_rdy && win_vld) begin
          gnt_d   = win_idx;
          txd_d   = din[{win_idx, 3'b000} +: 8];
          state_d = S_LOAD;
        end
      end
      S_LOAD:      state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!tx_rdy) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (tx_rdy) begin
          state_d = S_IDLE;
          ptr_d   = gnt_q + 2'd1;
        end
      end
      default:     state_d = S_IDLE;
    endcase
    // Watchdog abort skips the stuck transmitter and moves fairness past it.
    if (wd_hit) begin
      state_d = S_IDLE;
      ptr_d   = gnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 2'd0;
      txd_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      txd_q   <= txd_d;
    end
  end

  assign tx_en  = (state_q == S_LOAD);
  assign busy   = (state_q != S_IDLE);
  assign gnt_id = gnt_q;
  assign tx_din = txd_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_ack
    assign ack[g] = tx_en && (gnt_q == 2'(g));
  end

endmodule
